gpio_apb_bridge: RTL

GPIO_APB_BRIDGE -- requirements
Module: gpio_apb_bridge

---
 rtl/gpio_apb_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gpio_apb_bridge.sv
// gpio_apb_bridge: APB slave front end for a word-addressed GPIO register file.
// A transfer is captured in SETUP, optionally stretched by WAIT_STATES access
// cycles, and completed with a one-cycle registered pready/pslverr/gpio_we pulse.
// Writes are byte-lane merged against the current register value, so the
// register file always receives a full 32-bit word (read-modify-write).
module gpio_apb_bridge #(
  parameter int unsigned   WAIT_STATES = 0,
  parameter logic [31:0]   LAST_ADDR   = 32'h0000_0020
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        gpio_we,
  output logic [31:0] gpio_addr,
  output logic [31:0] gpio_data_i,
  input  logic [31:0] gpio_data_o,
  input  logic        gpio_inta_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] WS_L = WAIT_STATES[3:0];

  // Expand the four byte strobes into a 32-bit lane mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  // Misaligned, out-of-range, or a write to the read-only input register.
  function automatic logic addr_err(input logic [31:0] a, input logic wr);
    return (a[1:0] != 2'b00) || (a > LAST_ADDR) || (wr && (a == 32'h0000_0000));
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] gpio_addr_q, gpio_addr_d;
  logic [31:0] gpio_data_i_q, gpio_data_i_d;
  logic [31:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic        gpio_we_q, gpio_we_d;
  logic        irq_q, irq_d;
  logic        err_s;
  logic [31:0] mask_s;
  logic [31:0] merged_s;

  assign err_s    = addr_err(gpio_addr_q, wr_q);
  assign mask_s   = strb_mask(strb_q);
  assign merged_s = (wdata_q & mask_s) | (gpio_data_o & ~mask_s);

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    gpio_addr_d   = gpio_addr_q;
    gpio_data_i_d = gpio_data_i_q;
    prdata_d      = 32'h0000_0000;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    gpio_we_d     = 1'b0;
    irq_d         = gpio_inta_o;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          gpio_addr_d = paddr;
          wr_d        = pwrite;
          wdata_d     = pwdata;
          strb_d      = pstrb;
          cnt_d       = WS_L;
          state_d     = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (psel && penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = WAIT;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = err_s;
            if (err_s) begin
              prdata_d = 32'h0000_0000;
            end else if (wr_q) begin
              gpio_data_i_d = merged_s;
              gpio_we_d     = 1'b1;
            end else begin
              prdata_d = gpio_data_o;
            end
            state_d = RESP;
          end
        end else begin
          // Master withdrew the transfer: drop it silently.
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      wr_q          <= 1'b0;
      wdata_q       <= 32'h0000_0000;
      strb_q        <= 4'h0;
      gpio_addr_q   <= 32'h0000_0000;
      gpio_data_i_q <= 32'h0000_0000;
      prdata_q      <= 32'h0000_0000;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      gpio_we_q     <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      gpio_addr_q   <= gpio_addr_d;
      gpio_data_i_q <= gpio_data_i_d;
      prdata_q      <= prdata_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      gpio_we_q     <= gpio_we_d;
      irq_q         <= irq_d;
    end
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign gpio_we     = gpio_we_q;
  assign gpio_addr   = gpio_addr_q;
  assign gpio_data_i = gpio_data_i_q;
  assign irq_o       = irq_q;

endmodule
